// File: rtl/abr_sram_pkg.sv
// abr_sram_pkg: shared types and byte-strobe merge helper for the byte-enable SRAM responders
//   ABR_MAX_W      widest data word the merge helper handles
//   abr_zs_state_e zeroize sweep states
//   abr_be_merge   old word with strobed byte lanes replaced by new data
package abr_sram_pkg;

    localparam int ABR_MAX_W = 1024;

    typedef enum logic {ZS_IDLE, ZS_ZERO} abr_zs_state_e;

    // Callers zero-extend narrower words and truncate the result back to their width.
    function automatic logic [ABR_MAX_W-1:0] abr_be_merge(
        input logic [ABR_MAX_W-1:0]   old_w,
        input logic [ABR_MAX_W-1:0]   new_w,
        input logic [ABR_MAX_W/8-1:0] strb
    );
        logic [ABR_MAX_W-1:0] r;
        r = old_w;
        for (int k = 0; k < ABR_MAX_W / 8; k++)
            if (strb[k]) r[8*k+:8] = new_w[8*k+:8];
        return r;
    endfunction

endpackage

// File: rtl/abr_sram_zeroize_fsm.sv
// abr_sram_zeroize_fsm: sweep sequencer that clears every array word after a zeroize request
//   clk, rst      clock, asynchronous active-high reset
//   zeroize_i     start / restart the sweep
//   busy_o        high while the sweep runs
//   zero_done_o   pulse during the cycle that writes the last word
//   zero_we_o     array write enable for the sweep
//   zero_addr_o   word being cleared this cycle
module abr_sram_zeroize_fsm
    import abr_sram_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          zeroize_i,
    output logic          busy_o,
    output logic          zero_done_o,
    output logic          zero_we_o,
    output logic [IW-1:0] zero_addr_o
);

    // One extra bit keeps the last-word compare from ever wrapping.
    localparam int CW = $clog2(DEPTH) + 1;

    abr_zs_state_e state_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q;
    logic          done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ZS_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ZS_IDLE: begin
                    if (zeroize_i) begin
                        state_q <= ZS_ZERO;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= (DEPTH == 1);
                    end
                end
                ZS_ZERO: begin
                    if (zeroize_i) begin
                        // Restart: the aborted pass never reaches its done pulse.
                        cnt_q  <= '0;
                        done_q <= (DEPTH == 1);
                    end else if (cnt_q == CW'(DEPTH - 1)) begin
                        state_q <= ZS_IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q  <= cnt_q + 1'b1;
                        // Done is registered, so it is raised on the way into the last word.
                        done_q <= (cnt_q == CW'(DEPTH - 2));
                    end
                end
                default: state_q <= ZS_IDLE;
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign zero_done_o = done_q;
    assign zero_we_o   = (state_q == ZS_ZERO);
    assign zero_addr_o = cnt_q[IW-1:0];

endmodule

// File: rtl/abr_sram_be_resp_mem.sv
// abr_sram_be_resp_mem: byte-strobe SRAM responder with 1-cycle reads, collision policy and zeroize sweep
//   clk, rst        clock, asynchronous active-high reset
//   we_i, waddr_i, wdata_i, wstrobe_i   byte-strobed write request
//   re_i, raddr_i   read request; rdata_o valid after the next edge and held otherwise
//   zeroize_i       start / restart the clear sweep
//   busy_o          sweep running; requests are ignored
//   zero_done_o     pulse on the last sweep write
//   oob_err_o       pulse the cycle after an access with address >= DEPTH
module abr_sram_be_resp_mem
    import abr_sram_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 64,
    parameter int RAW_FWD = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we_i,
    input  logic [ADDR_W-1:0]   waddr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] wstrobe_i,
    input  logic                re_i,
    input  logic [ADDR_W-1:0]   raddr_i,
    output logic [DATA_W-1:0]   rdata_o,
    input  logic                zeroize_i,
    output logic                busy_o,
    output logic                zero_done_o,
    output logic                oob_err_o
);

    localparam int             IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);

    if (DATA_W % 8 != 0 || DATA_W > ABR_MAX_W) begin : g_bad_width
        $error("abr_sram_be_resp_mem: DATA_W must be a multiple of 8 and at most ABR_MAX_W");
    end

    logic              zero_we;
    logic [IW-1:0]     zero_addr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              w_oob, r_oob, wen;
    logic [IW-1:0]     widx, ridx;
    logic [DATA_W-1:0] wr_m;
    logic [DATA_W-1:0] rdata_d, rdata_q;
    logic              oob_d, oob_q;

    abr_sram_zeroize_fsm #(.DEPTH(DEPTH), .IW(IW)) u_zfsm (
        .clk         (clk),
        .rst         (rst),
        .zeroize_i   (zeroize_i),
        .busy_o      (busy_o),
        .zero_done_o (zero_done_o),
        .zero_we_o   (zero_we),
        .zero_addr_o (zero_addr)
    );

    assign w_oob = {1'b0, waddr_i} >= DEPTH_A;
    assign r_oob = {1'b0, raddr_i} >= DEPTH_A;
    assign widx  = waddr_i[IW-1:0];
    assign ridx  = raddr_i[IW-1:0];
    assign wen   = !busy_o && we_i && !w_oob;
    // Merged write word; also the forwarded read value on a same-address collision.
    assign wr_m  = DATA_W'(abr_be_merge(ABR_MAX_W'(mem[widx]), ABR_MAX_W'(wdata_i),
                                        (ABR_MAX_W / 8)'(wstrobe_i)));

    // Sweep writes take priority over the requester.
    always_ff @(posedge clk) begin
        if (zero_we) mem[zero_addr] <= '0;
        else if (wen) mem[widx] <= wr_m;
    end

    always_comb begin
        rdata_d = (busy_o || zeroize_i) ? '0 :
                  !re_i                 ? rdata_q :
                  r_oob                 ? '0 :
                  (RAW_FWD != 0 && wen && raddr_i == waddr_i) ? wr_m : mem[ridx];
        oob_d   = !busy_o && ((we_i && w_oob) || (re_i && r_oob));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
            oob_q   <= 1'b0;
        end else begin
            rdata_q <= rdata_d;
            oob_q   <= oob_d;
        end
    end

    assign rdata_o   = rdata_q;
    assign oob_err_o = oob_q;

endmodule

// File: tb/tb_abr_sram_be_resp_mem.sv
// tb_abr_sram_be_resp_mem: directed bench for the byte-strobe SRAM responder (read-first and write-first copies)
module tb_abr_sram_be_resp_mem;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0, re = 1'b0, zeroize = 1'b0;
    logic [15:0] waddr = '0, raddr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrobe = '0;
    logic [31:0] r0, r1;
    logic        b0, b1, d0, d1, e0, e1;
    int          n_eval = 0;
    int          n_fail = 0;
    int          n, dn, da;

    always #5 clk = ~clk;

    abr_sram_be_resp_mem #(.ADDR_W(16), .DATA_W(32), .DEPTH(64), .RAW_FWD(0)) dut0 (
        .clk(clk), .rst(rst), .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .wstrobe_i(wstrobe),
        .re_i(re), .raddr_i(raddr), .rdata_o(r0), .zeroize_i(zeroize), .busy_o(b0),
        .zero_done_o(d0), .oob_err_o(e0)
    );

    abr_sram_be_resp_mem #(.ADDR_W(16), .DATA_W(32), .DEPTH(64), .RAW_FWD(1)) dut1 (
        .clk(clk), .rst(rst), .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .wstrobe_i(wstrobe),
        .re_i(re), .raddr_i(raddr), .rdata_o(r1), .zeroize_i(zeroize), .busy_o(b1),
        .zero_done_o(d1), .oob_err_o(e1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_eval++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        we = 1'b1; waddr = a; wdata = d; wstrobe = s;
        step();
        we = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a);
        re = 1'b1; raddr = a;
        step();
        re = 1'b0;
    endtask

    // Pulses zeroize and follows the sweep; throws requests at it mid-way and optionally re-pulses at cycle rs_at.
    task automatic sweep(input int rs_at, output int cyc, output int ndone, output int done_at);
        cyc = 0; ndone = 0; done_at = 0;
        zeroize = 1'b1;
        step();
        zeroize = 1'b0;
        while (b0 && cyc < 200) begin
            cyc++;
            if (d0) begin
                ndone++;
                done_at = cyc;
            end
            chk("sweep_rdata0", r0, 32'h0);
            chk("sweep_rdata1", r1, 32'h0);
            chk("sweep_oob", 32'(e0), 32'h0);
            we      = (cyc == 5) || (cyc == 6);
            waddr   = (cyc == 6) ? 16'd70 : 16'd0;
            wdata   = 32'hFFFF_FFFF;
            wstrobe = 4'hF;
            re      = (cyc == 5) || (cyc == 6);
            raddr   = (cyc == 6) ? 16'd64 : 16'd6;
            zeroize = (cyc == rs_at);
            step();
        end
        we = 1'b0; re = 1'b0; zeroize = 1'b0;
    endtask

    initial begin
        #3;
        chk("rst_rdata", r0, 32'h0);
        chk("rst_busy", 32'(b0), 32'h0);
        chk("rst_done", 32'(d0), 32'h0);
        chk("rst_oob", 32'(e0), 32'h0);
        step();
        rst = 1'b0;

        wr(16'd5, 32'hDEAD_BEEF, 4'hF);
        rd(16'd5);
        chk("rd_full0", r0, 32'hDEAD_BEEF);
        chk("rd_full1", r1, 32'hDEAD_BEEF);
        chk("rd_full_oob", 32'(e0), 32'h0);

        wr(16'd5, 32'h1122_3344, 4'h5);
        rd(16'd5);
        chk("rd_strb0", r0, 32'hDE22_BE44);
        chk("rd_strb1", r1, 32'hDE22_BE44);

        we = 1'b1; re = 1'b1; waddr = 16'd5; raddr = 16'd5; wdata = 32'h0; wstrobe = 4'hF;
        step();
        we = 1'b0; re = 1'b0;
        chk("coll_rfirst", r0, 32'hDE22_BE44);
        chk("coll_wfirst", r1, 32'h0000_0000);
        rd(16'd5);
        chk("coll_after0", r0, 32'h0);

        wr(16'd6, 32'hFFFF_FFFF, 4'hF);
        wr(16'd6, 32'h1234_5678, 4'h0);
        rd(16'd6);
        chk("strb_zero", r0, 32'hFFFF_FFFF);
        step();
        chk("rdata_hold", r0, 32'hFFFF_FFFF);

        rd(16'd64);
        chk("oob_rd_data", r0, 32'h0);
        chk("oob_rd_pulse", 32'(e0), 32'h1);
        step();
        chk("oob_rd_clear", 32'(e0), 32'h0);
        wr(16'd70, 32'hAAAA_AAAA, 4'hF);
        chk("oob_wr_pulse", 32'(e0), 32'h1);
        rd(16'd6);
        chk("oob_wr_unchanged", r0, 32'hFFFF_FFFF);
        chk("oob_wr_clear", 32'(e0), 32'h0);
        we = 1'b1; waddr = 16'd70; re = 1'b1; raddr = 16'd64;
        step();
        we = 1'b0; re = 1'b0;
        chk("oob_both_pulse", 32'(e0), 32'h1);
        step();
        chk("oob_both_single", 32'(e0), 32'h0);
        rd(16'd63);
        chk("rd_last_word_x", 32'(e0), 32'h0);

        wr(16'd0, 32'h0BAD_F00D, 4'hF);
        wr(16'd63, 32'h5555_AAAA, 4'hF);
        rd(16'd63);
        chk("pre_sweep_63", r0, 32'h5555_AAAA);

        sweep(-1, n, dn, da);
        chk("sweep_len", n, 64);
        chk("sweep_ndone", dn, 1);
        chk("sweep_done_at", da, 64);
        chk("sweep_busy_low", 32'(b0), 32'h0);
        rd(16'd0);
        chk("sweep_rd0", r0, 32'h0);
        rd(16'd63);
        chk("sweep_rd63", r0, 32'h0);
        rd(16'd6);
        chk("sweep_rd6", r0, 32'h0);
        wr(16'd63, 32'hCAFE_F00D, 4'hF);
        rd(16'd63);
        chk("post_sweep_wr", r0, 32'hCAFE_F00D);

        sweep(11, n, dn, da);
        chk("restart_len", n, 75);
        chk("restart_ndone", dn, 1);
        chk("restart_done_at", da, 75);
        rd(16'd63);
        chk("restart_rd63", r0, 32'h0);

        wr(16'd9, 32'h1357_9BDF, 4'hF);
        rd(16'd9);
        chk("pre_rst_rd", r0, 32'h1357_9BDF);
        zeroize = 1'b1;
        step();
        zeroize = 1'b0;
        chk("rst_sweep_busy", 32'(b0), 32'h1);
        chk("rst_sweep_rdata", r0, 32'h0);
        repeat (19) step();
        chk("rst_sweep_busy20", 32'(b0), 32'h1);
        rst = 1'b1;
        #2;
        chk("async_rst_busy", 32'(b0), 32'h0);
        chk("async_rst_rdata", r0, 32'h0);
        chk("async_rst_done", 32'(d0), 32'h0);
        step();
        rst = 1'b0;
        step();
        chk("after_rst_busy", 32'(b0), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
        $finish;
    end

endmodule
